// File: rtl/aes_mac_engine.sv
// Streaming AES-128 CBC encryptor: gathers a 4-word block and key, runs one
// round per cycle with on-the-fly key expansion, and streams out 4 cipher words.
module aes_mac_engine #(
  parameter logic [127:0] IV = 128'h000102030405060708090a0b0c0d0e0f
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        a_valid_i,
  output logic        a_ready_o,
  input  logic [31:0] a_data_i,
  input  logic [3:0]  a_strb_i,
  input  logic        b_valid_i,
  output logic        b_ready_o,
  input  logic [31:0] b_data_i,
  input  logic [3:0]  b_strb_i,
  output logic        d_valid_o,
  input  logic        d_ready_i,
  output logic [31:0] d_data_o,
  output logic [3:0]  d_strb_o,
  input  logic        ctrl_clear_i,
  input  logic        ctrl_enable_i,
  output logic        flags_busy_o,
  output logic        flags_done_o
);

  typedef enum logic [1:0] {LOAD, INIT, ROUND, OUT} state_e;

  state_e       st_q, st_d;
  logic [2:0]   a_cnt_q, b_cnt_q, a_cnt_nx, b_cnt_nx;
  logic [3:0]   rnd_q;
  logic [1:0]   idx_q;
  logic [127:0] a_buf_q, b_buf_q, blk_q, rk_q, chain_q;
  logic [127:0] rk_next, round_out;
  logic [31:0]  out_word;
  logic [7:0]   rcon;
  logic         run, a_hs, b_hs, d_hs, last_word;
  logic         strb_unused;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed algebraically: x^254 is the field inverse (0 maps to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = gf_mul(a, a);
    inv = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte i of the block sits at row i%4, column i/4; ShiftRows pulls from column (c+r)%4.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [127:0] sr, mc;
    logic [7:0]   a0, a1, a2, a3;
    sr = '0;
    for (int i = 0; i < 16; i++)
      sr[127-8*i -: 8] = sbox(s[127-8*((i%4) + 4*(((i/4) + (i%4)) % 4)) -: 8]);
    mc = sr;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = sr[127-32*c -: 8];
        a1 = sr[119-32*c -: 8];
        a2 = sr[111-32*c -: 8];
        a3 = sr[103-32*c -: 8];
        mc[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
    end
    return mc ^ k;
  endfunction

  always_comb begin
    rcon = 8'h00;
    case (rnd_q)
      4'd1:  rcon = 8'h01;
      4'd2:  rcon = 8'h02;
      4'd3:  rcon = 8'h04;
      4'd4:  rcon = 8'h08;
      4'd5:  rcon = 8'h10;
      4'd6:  rcon = 8'h20;
      4'd7:  rcon = 8'h40;
      4'd8:  rcon = 8'h80;
      4'd9:  rcon = 8'h1b;
      4'd10: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign rk_next   = key_next(rk_q, rcon);
  assign round_out = aes_round(blk_q, rk_next, rnd_q == 4'd10);

  // Handshakes are impossible while in reset, clearing or frozen.
  assign run       = rst_ni & ctrl_enable_i & ~ctrl_clear_i;
  assign a_ready_o = run & (st_q == LOAD) & ~a_cnt_q[2];
  assign b_ready_o = run & (st_q == LOAD) & ~b_cnt_q[2];
  assign d_valid_o = run & (st_q == OUT);
  assign a_hs      = a_valid_i & a_ready_o;
  assign b_hs      = b_valid_i & b_ready_o;
  assign d_hs      = d_valid_o & d_ready_i;
  assign last_word = d_hs & (idx_q == 2'd3);
  assign a_cnt_nx  = a_cnt_q + {2'b00, a_hs};
  assign b_cnt_nx  = b_cnt_q + {2'b00, b_hs};

  always_comb begin
    out_word = blk_q[127:96];
    case (idx_q)
      2'd1:    out_word = blk_q[95:64];
      2'd2:    out_word = blk_q[63:32];
      2'd3:    out_word = blk_q[31:0];
      default: out_word = blk_q[127:96];
    endcase
  end

  assign d_data_o     = (rst_ni && st_q == OUT) ? out_word : 32'h0;
  assign d_strb_o     = 4'hF;
  assign flags_done_o = last_word;
  assign flags_busy_o = rst_ni & ((st_q != LOAD) | (a_cnt_q != 3'd0) | (b_cnt_q != 3'd0));
  assign strb_unused  = ^{a_strb_i, b_strb_i};

  always_comb begin
    st_d = st_q;
    case (st_q)
      LOAD:    if (a_cnt_nx == 3'd4 && b_cnt_nx == 3'd4) st_d = INIT;
      INIT:    st_d = ROUND;
      ROUND:   if (rnd_q == 4'd10) st_d = OUT;
      OUT:     if (last_word) st_d = LOAD;
      default: st_d = LOAD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || ctrl_clear_i) begin
      st_q    <= LOAD;
      a_cnt_q <= 3'd0;
      b_cnt_q <= 3'd0;
      rnd_q   <= 4'd0;
      idx_q   <= 2'd0;
      chain_q <= IV;
    end else if (ctrl_enable_i) begin
      st_q    <= st_d;
      a_cnt_q <= (st_d == INIT) ? 3'd0 : a_cnt_nx;
      b_cnt_q <= (st_d == INIT) ? 3'd0 : b_cnt_nx;
      if (st_q == INIT)       rnd_q <= 4'd1;
      else if (st_q == ROUND) rnd_q <= rnd_q + 4'd1;
      if (d_hs)      idx_q   <= idx_q + 2'd1;
      if (last_word) chain_q <= blk_q;
    end
  end

  // Data registers carry no reset; the control path decides when they matter.
  always_ff @(posedge clk_i) begin
    if (a_hs) a_buf_q <= {a_buf_q[95:0], a_data_i};
    if (b_hs) b_buf_q <= {b_buf_q[95:0], b_data_i};
    if (run && st_q == INIT) begin
      blk_q <= a_buf_q ^ b_buf_q ^ chain_q;
      rk_q  <= b_buf_q;
    end else if (run && st_q == ROUND) begin
      blk_q <= round_out;
      rk_q  <= rk_next;
    end
  end

endmodule

// File: tb/tb_aes_mac_engine.sv
// Directed bench for aes_mac_engine using the NIST SP800-38A CBC-AES128 vectors.
module tb_aes_mac_engine;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        a_valid_i, a_ready_o, b_valid_i, b_ready_o;
  logic [31:0] a_data_i, b_data_i, d_data_o;
  logic [3:0]  a_strb_i, b_strb_i, d_strb_o;
  logic        d_valid_o, d_ready_i;
  logic        ctrl_clear_i, ctrl_enable_i;
  logic        flags_busy_o, flags_done_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] P3  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] P4  = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] C3  = 128'h73bed6b8e3c1743b7116e69e22229516;
  localparam logic [127:0] C4  = 128'h3ff1caa1681fac09120eca307586e1a7;

  logic [15:0] pat = 16'b1011_0010_1100_1101;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_mac_engine #(.IV(128'h000102030405060708090a0b0c0d0e0f)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_data_i(a_data_i), .a_strb_i(a_strb_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_data_i(b_data_i), .b_strb_i(b_strb_i),
    .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_data_o(d_data_o), .d_strb_o(d_strb_o),
    .ctrl_clear_i(ctrl_clear_i), .ctrl_enable_i(ctrl_enable_i),
    .flags_busy_o(flags_busy_o), .flags_done_o(flags_done_o)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wsel(input logic [127:0] b, input int i);
    return b[127-32*i -: 32];
  endfunction

  task automatic send_block(input logic [127:0] pt, input logic [127:0] key,
                            input int kdel, output int t_last);
    int na = 0;
    int nb = 0;
    int c = 0;
    t_last = 0;
    while ((na < 4 || nb < 4) && c < 100) begin
      @(negedge clk);
      a_valid_i = (na < 4);
      a_data_i  = (na < 4) ? wsel(pt, na) : 32'h0;
      b_valid_i = (nb < 4) && (c >= kdel);
      b_data_i  = (nb < 4) ? wsel(key, nb) : 32'h0;
      #1;
      if (a_valid_i && a_ready_o) begin na++; t_last = cyc + 1; end
      if (b_valid_i && b_ready_o) begin nb++; t_last = cyc + 1; end
      c++;
    end
    @(posedge clk);
    #1;
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    check("send_words", na + nb, 8);
  endtask

  // mode 0: ready always high; 1: irregular ready; 2: enable low 5 cycles after first word
  task automatic recv_block(input logic [127:0] exp, input int mode, input int t_last,
                            input int exp_lat, input int exp_span);
    int n = 0;
    int w = 0;
    int k = 0;
    int first = -1;
    int dones = 0;
    int done_cyc = 0;
    logic held = 1'b0;
    logic [31:0] hdata = 32'h0;
    while (n < 4 && w < 200) begin
      @(negedge clk);
      d_ready_i = (mode == 1) ? pat[cyc % 16] : 1'b1;
      if (mode == 2 && n == 1 && k < 5) begin ctrl_enable_i = 1'b0; k++; end
      else ctrl_enable_i = 1'b1;
      #1;
      if (!ctrl_enable_i) check("frozen_valid", d_valid_o, 0);
      if (held) begin
        check("hold_valid", d_valid_o, 1);
        check("hold_data", d_data_o, hdata);
      end
      if (d_valid_o) begin
        if (first < 0) begin
          first = cyc;
          if (exp_lat >= 0) check("latency", cyc - t_last, exp_lat);
        end
        if (d_ready_i) begin
          check("cipher_word", d_data_o, wsel(exp, n));
          check("done_flag", flags_done_o, n == 3);
          if (flags_done_o) dones++;
          if (n == 3) done_cyc = cyc;
          n++;
          held = 1'b0;
        end else begin
          held  = 1'b1;
          hdata = d_data_o;
        end
      end
      w++;
    end
    check("out_words", n, 4);
    check("done_count", dones, 1);
    if (exp_span >= 0) check("out_span", done_cyc - first, exp_span);
    @(negedge clk);
    ctrl_enable_i = 1'b1;
    d_ready_i     = 1'b0;
    #1;
    check("ready_next", a_ready_o, 1);
  endtask

  initial begin
    int t;
    int seen;
    rst_ni = 1'b0; ctrl_enable_i = 1'b1; ctrl_clear_i = 1'b0;
    a_valid_i = 1'b0; b_valid_i = 1'b0; a_data_i = '0; b_data_i = '0;
    a_strb_i = 4'hF; b_strb_i = 4'hF; d_ready_i = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_a_ready", a_ready_o, 0);
    check("rst_b_ready", b_ready_o, 0);
    check("rst_d_valid", d_valid_o, 0);
    check("rst_d_data", d_data_o, 0);
    check("rst_busy", flags_busy_o, 0);
    check("rst_done", flags_done_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    #1;
    check("rel_a_ready", a_ready_o, 1);
    check("rel_b_ready", b_ready_o, 1);
    check("d_strb", d_strb_o, 4'hF);

    send_block(P1, KEY, 0, t);
    recv_block(C1, 0, t, 11, 3);

    // clear restores the IV, so vector 1 repeats
    @(negedge clk);
    ctrl_clear_i = 1'b1;
    #1;
    check("clr_a_ready", a_ready_o, 0);
    @(negedge clk);
    ctrl_clear_i = 1'b0;
    #1;
    check("clr_busy", flags_busy_o, 0);
    check("clr_a_ready_after", a_ready_o, 1);

    send_block(P1, KEY, 0, t);
    recv_block(C1, 0, t, 11, 3);
    send_block(P2, KEY, 2, t);
    recv_block(C2, 0, t, 11, 3);
    send_block(P3, KEY, 0, t);
    recv_block(C3, 1, t, 11, -1);
    send_block(P4, KEY, 5, t);
    recv_block(C4, 0, t, 11, 3);

    // freeze mid-ROUND and during OUT
    @(negedge clk);
    ctrl_clear_i = 1'b1;
    @(negedge clk);
    ctrl_clear_i = 1'b0;
    send_block(P1, KEY, 0, t);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      ctrl_enable_i = 1'b0;
      #1;
      check("frz_a_ready", a_ready_o, 0);
      check("frz_busy", flags_busy_o, 1);
      @(negedge clk);
    end
    ctrl_enable_i = 1'b1;
    recv_block(C1, 2, t, 16, 8);

    // reset mid-ROUND aborts the block
    send_block(P2, KEY, 0, t);
    repeat (3) @(negedge clk);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_a_ready", a_ready_o, 0);
    check("mid_rst_busy", flags_busy_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    check("post_rst_busy", flags_busy_o, 0);
    check("post_rst_d_data", d_data_o, 0);
    seen = 0;
    d_ready_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      #1;
      if (d_valid_o) seen++;
    end
    d_ready_i = 1'b0;
    check("aborted_outputs", seen, 0);
    send_block(P1, KEY, 1, t);
    recv_block(C1, 0, t, 11, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
